// File: rtl/us_ranger_apb.sv
// us_ranger_apb: APB multi-channel ultrasonic ranger for HC-SR04-class sensors.
// Channels fire one at a time in round-robin order, with a holdoff gap between shots.
// Optional macro US_IRQ_EN enables the level interrupt and makes CTRL[2] writable.
module us_ranger_apb #(
  parameter int NUM_CH      = 2,
  parameter int CLK_HZ      = 100_000_000,
  parameter int TRIG_US     = 10,
  parameter int WAIT_MAX_US = 5000,
  parameter int ECHO_MAX_US = 25000,
  parameter int GAP_US      = 60000,
  parameter int DIST_W      = 9
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [4:0]        PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic [NUM_CH-1:0] trigger,
  input  logic [NUM_CH-1:0] echo,
  output logic              irq
);
  localparam int DIV    = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
  localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MAX_A  = (TRIG_US > WAIT_MAX_US) ? TRIG_US : WAIT_MAX_US;
  localparam int MAX_B  = (ECHO_MAX_US > GAP_US) ? ECHO_MAX_US : GAP_US;
  localparam int MAX_US = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W  = $clog2(MAX_US + 1);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = CNT_W + DIST_W + 11;
  localparam logic [PROD_W-1:0] DIST_MAX = PROD_W'((64'd1 << DIST_W) - 64'd1);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_HIGH, S_DONE, S_ERR, S_GAP} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [CH_W-1:0]                ch_q, ch_d;
  logic [PRE_W-1:0]               pre_q, pre_d;
  logic [NUM_CH-1:0]              sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic                           cont_q, cont_d, irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]              ch_en_q, ch_en_d, done_q, done_d, err_q, err_d;
  logic [NUM_CH-1:0]              vld_q, vld_d;
  logic [NUM_CH-1:0][DIST_W-1:0]  dist_q, dist_d;
  logic                           pready_q, pready_d, irq_q, irq_d;
  logic [31:0]                    prdata_q, prdata_d, rdata;

  logic              tick, echo_rise, echo_fall;
  logic              acc, wr, rd, wr_ctrl, wr_stat, start_ok;
  logic [2:0]        idx;
  logic [NUM_CH-1:0] above, set_done, set_err;
  logic              data_we, data_vld;
  logic [DIST_W-1:0] data_dist, dist_sat;
  logic [PROD_W-1:0] prod, dist_full;
  logic              unused_ok;

  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i]) r = CH_W'(i);
    return r;
  endfunction

  // APB decode: one wait state, access only in the cycle before PREADY rises
  assign idx      = PADDR[4:2];
  assign acc      = PSEL & PENABLE & ~pready_q;
  assign wr       = acc & PWRITE;
  assign rd       = acc & ~PWRITE;
  assign wr_ctrl  = wr & (idx == 3'd0);
  assign wr_stat  = wr & (idx == 3'd1);
  assign start_ok = wr_ctrl & PWDATA[0] & (state_q == S_IDLE) & (|PWDATA[8 +: NUM_CH]);
  assign unused_ok = ^{PWDATA, PADDR[1:0]};

  // us prescaler only runs during a sweep, so every sweep starts phase-aligned
  assign tick      = (state_q != S_IDLE) && (pre_q == PRE_W'(DIV - 1));
  assign echo_rise = sync2_q[ch_q] & ~prev_q[ch_q];
  assign echo_fall = ~sync2_q[ch_q] & prev_q[ch_q];

  // Distance ~ us/58, full-width product then saturate into the field
  always_comb begin
    prod      = PROD_W'(cnt_q) * PROD_W'(11'd1130);
    dist_full = prod >> 16;
    dist_sat  = (dist_full > DIST_MAX) ? '1 : dist_full[DIST_W-1:0];
  end

  // Echo synchroniser, edge history and prescaler next state
  always_comb begin
    sync1_d = echo;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pre_d   = '0;
    if (state_q != S_IDLE) pre_d = tick ? '0 : pre_q + 1'b1;
  end

  // Shot sequencer: next state, channel selection and result write-back
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    set_done  = '0;
    set_err   = '0;
    data_we   = 1'b0;
    data_vld  = 1'b0;
    data_dist = '0;
    above     = '0;
    for (int i = 0; i < NUM_CH; i++) above[i] = ch_en_q[i] && (i > int'(ch_q));
    if (tick) cnt_d = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: if (start_ok) begin
        state_d = S_TRIG;
        ch_d    = lowest(PWDATA[8 +: NUM_CH]);
      end
      S_TRIG: if (tick && cnt_q == CNT_W'(TRIG_US - 1)) state_d = S_WAIT;
      S_WAIT: begin
        // only a rise seen here counts, so an echo already high times out
        if (echo_rise) state_d = S_HIGH;
        else if (tick && cnt_q == CNT_W'(WAIT_MAX_US - 1)) state_d = S_ERR;
      end
      S_HIGH: begin
        if (echo_fall) state_d = S_DONE;
        else if (tick && cnt_q == CNT_W'(ECHO_MAX_US - 1)) state_d = S_ERR;
      end
      S_DONE: begin
        set_done[ch_q] = 1'b1;
        data_we        = 1'b1;
        data_vld       = 1'b1;
        data_dist      = dist_sat;
        state_d        = S_GAP;
      end
      S_ERR: begin
        set_err[ch_q] = 1'b1;
        data_we       = 1'b1;
        state_d       = S_GAP;
      end
      S_GAP: if (tick && cnt_q == CNT_W'(GAP_US - 1)) begin
        // CH_EN/CONT are sampled here, so mid-sweep edits apply at the next pick
        if (|above) begin
          state_d = S_TRIG;
          ch_d    = lowest(above);
        end else if (cont_q && (|ch_en_q)) begin
          state_d = S_TRIG;
          ch_d    = lowest(ch_en_q);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // DONE keeps the HIGH count for the distance calculation
    if (state_d != state_q && state_d != S_DONE) cnt_d = '0;
  end

  // Trigger is decoded from flops so an async reset drops it at once
  always_comb begin
    trigger = '0;
    if (state_q == S_TRIG) trigger[ch_q] = 1'b1;
  end

  // Register file updates; a hardware set beats a same-cycle W1C
  always_comb begin
    cont_d   = cont_q;
    irq_en_d = irq_en_q;
    ch_en_d  = ch_en_q;
    done_d   = done_q;
    err_d    = err_q;
    dist_d   = dist_q;
    vld_d    = vld_q;
    if (wr_ctrl) begin
      cont_d  = PWDATA[1];
`ifdef US_IRQ_EN
      irq_en_d = PWDATA[2];
`endif
      ch_en_d = PWDATA[8 +: NUM_CH];
    end
    if (wr_stat) begin
      done_d = done_q & ~PWDATA[8 +: NUM_CH];
      err_d  = err_q & ~PWDATA[16 +: NUM_CH];
    end
    done_d = done_d | set_done;
    err_d  = err_d | set_err;
    if (data_we) begin
      dist_d[ch_q] = data_dist;
      vld_d[ch_q]  = data_vld;
    end
`ifdef US_IRQ_EN
    irq_d = irq_en_q & (|(done_q | err_q));
`else
    irq_d = 1'b0;
`endif
  end

  // Read mux; unmapped words return zero
  always_comb begin
    rdata = '0;
    case (idx)
      3'd0: begin
        rdata[1]            = cont_q;
        rdata[2]            = irq_en_q;
        rdata[8 +: NUM_CH]  = ch_en_q;
      end
      3'd1: begin
        rdata[0]            = (state_q != S_IDLE);
        rdata[8 +: NUM_CH]  = done_q;
        rdata[16 +: NUM_CH] = err_q;
      end
      default: begin
        for (int k = 0; k < NUM_CH; k++)
          if (idx == 3'(k + 2)) begin
            rdata[31]         = vld_q[k];
            rdata[DIST_W-1:0] = dist_q[k];
          end
      end
    endcase
    pready_d = acc;
    prdata_d = rd ? rdata : prdata_q;
  end

  // State registers
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ch_q     <= '0;
      pre_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      cont_q   <= 1'b0;
      irq_en_q <= 1'b0;
      ch_en_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      vld_q    <= '0;
      dist_q   <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      pre_q    <= pre_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      cont_q   <= cont_d;
      irq_en_q <= irq_en_d;
      ch_en_q  <= ch_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      dist_q   <= dist_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      irq_q    <= irq_d;
    end
  end

  assign PREADY = pready_q;
  assign PRDATA = prdata_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_us_ranger_apb.sv
// Bench for us_ranger_apb: shrunken timing (2 clocks per us), vector table of
// sweeps plus hand sequences; trigger pulses are checked against a queue of
// expected channels pushed when each START is issued.
module tb_us_ranger_apb;
  localparam int NCH = 2;
  localparam int DIV = 2;
  localparam int TRIG_US = 10;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic [4:0]  PADDR = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [NCH-1:0] trigger;
  logic [NCH-1:0] echo_w;
  logic        irq;
  logic        echo_r0 = 1'b0, echo_r1 = 1'b0;
  int          echo_us0 = 0, echo_us1 = 0;
  int          total = 0, bad = 0;
  int          exp_q[$];
  logic        overlap_seen = 1'b0;

  assign echo_w = {echo_r1, echo_r0};

  us_ranger_apb #(.NUM_CH(NCH), .CLK_HZ(2_000_000), .TRIG_US(TRIG_US), .WAIT_MAX_US(50),
                  .ECHO_MAX_US(1500), .GAP_US(40), .DIST_W(9)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .trigger(trigger), .echo(echo_w), .irq(irq));

  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic apb(input logic w, input logic [4:0] a, input logic [31:0] wd, output logic [31:0] rdv);
    int n;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    do begin @(posedge PCLK); #1; n++; end while (!PREADY && n < 8);
    if (!PREADY) timeout("apb_ready");
    rdv = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    apb(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    apb(1'b0, a, 32'h0, d);
  endtask

  // poll STAT until (STAT & mask) == want
  task automatic wait_stat(input string nm, input logic [31:0] mask, input logic [31:0] want);
    logic [31:0] s;
    int n;
    n = 0;
    do begin rd(5'h04, s); n++; end while ((s & mask) != want && n < 3000);
    if ((s & mask) != want) timeout(nm);
  endtask

  task automatic wait_echo_low();
    int n;
    n = 0;
    while (echo_w != '0 && n < 10000) begin @(posedge PCLK); n++; end
    if (echo_w != '0) timeout("echo_low");
    repeat (5) @(posedge PCLK);
  endtask

  // Sensor models: echo rises 10 clocks after trigger falls; 0 us means no echo
  initial forever begin
    @(negedge trigger[0]);
    if (echo_us0 != 0 && PRESET) begin
      repeat (10) @(posedge PCLK);
      #1 echo_r0 = 1'b1;
      repeat (echo_us0 * DIV) @(posedge PCLK);
      #1 echo_r0 = 1'b0;
    end
  end

  initial forever begin
    @(negedge trigger[1]);
    if (echo_us1 != 0 && PRESET) begin
      repeat (10) @(posedge PCLK);
      #1 echo_r1 = 1'b1;
      repeat (echo_us1 * DIV) @(posedge PCLK);
      #1 echo_r1 = 1'b0;
    end
  end

  // Trigger monitor: channel order from the scoreboard, pulse width, no overlap
  initial begin
    logic [NCH-1:0] prev;
    logic [31:0]    m;
    int             width, e;
    prev = '0;
    width = 0;
    forever begin
      @(negedge PCLK);
      if ((trigger & (trigger - 2'd1)) != '0) overlap_seen = 1'b1;
      if (prev == '0 && trigger != '0) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL trig_unexpected: got %b want none", trigger);
        end else begin
          e = exp_q.pop_front();
          m = 32'd1 << e;
          chk("trig_channel", 32'(trigger), m);
        end
        width = 0;
      end
      if (trigger != '0) width++;
      if (prev != '0 && trigger == '0 && PRESET) chk("trig_width", width, TRIG_US * DIV);
      prev = trigger;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got running want finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  typedef struct {
    logic [31:0] ctrl;
    int          e0, e1;
    int          sh0, sh1;
    logic [31:0] d0, d1, stat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] r;
    // ctrl, echo0 us, echo1 us, expected shots, DATA0, DATA1, STAT
    vecs[0] = '{32'h301, 600, 1200,  0,  1, 32'h8000000A, 32'h80000014, 32'h00000300};
    vecs[1] = '{32'h101,   0,    0,  0, -1, 32'h00000000, 32'h80000014, 32'h00010000};
    vecs[2] = '{32'h201,   0,  300,  1, -1, 32'h00000000, 32'h80000005, 32'h00000200};
    vecs[3] = '{32'h101, 1600,   0,  0, -1, 32'h00000000, 32'h80000005, 32'h00010000};
    vecs[4] = '{32'h301, 100,    0,  0,  1, 32'h80000001, 32'h00000000, 32'h00020100};
    vecs[5] = '{32'h001, 600,  600, -1, -1, 32'h80000001, 32'h00000000, 32'h00000000};

    // reset state
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_trigger", 32'(trigger), 0);
    chk("rst_pready", 32'(PREADY), 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_irq", 32'(irq), 0);
    PRESET = 1'b1;
    rd(5'h00, r); chk("rst_ctrl", r, 0);
    rd(5'h04, r); chk("rst_stat", r, 0);
    rd(5'h08, r); chk("rst_data0", r, 0);
    rd(5'h0C, r); chk("rst_data1", r, 0);

    // writes to unmapped words are dropped
    wr(5'h18, 32'hFFFF_FFFF);
    wr(5'h1C, 32'hFFFF_FFFF);
    rd(5'h00, r); chk("unmapped_wr_ctrl", r, 0);
    rd(5'h04, r); chk("unmapped_wr_stat", r, 0);

    for (int i = 0; i < 6; i++) begin
      wait_echo_low();
      wr(5'h04, 32'h000F_0F00);
      echo_us0 = vecs[i].e0;
      echo_us1 = vecs[i].e1;
      if (vecs[i].sh0 >= 0) exp_q.push_back(vecs[i].sh0);
      if (vecs[i].sh1 >= 0) exp_q.push_back(vecs[i].sh1);
      wr(5'h00, vecs[i].ctrl);
      wait_stat($sformatf("v%0d_idle", i), 32'h1, 32'h0);
      rd(5'h08, r); chk($sformatf("v%0d_data0", i), r, vecs[i].d0);
      rd(5'h0C, r); chk($sformatf("v%0d_data1", i), r, vecs[i].d1);
      rd(5'h04, r); chk($sformatf("v%0d_stat", i), r, vecs[i].stat);
      chk($sformatf("v%0d_shots_left", i), exp_q.size(), 0);
    end

    // unmapped read with select held: PREADY pulses once, PRDATA clears to 0
    rd(5'h08, r);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 5'h1C;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("unm_ready_hi", 32'(PREADY), 1);
    chk("unm_prdata", PRDATA, 0);
    @(posedge PCLK); #1;
    chk("unm_ready_lo", 32'(PREADY), 0);
    PSEL = 1'b0; PENABLE = 1'b0;

    // continuous sweep on ch0: two shots, then CONT cleared ends the sweep
    wait_echo_low();
    wr(5'h04, 32'h000F_0F00);
    echo_us0 = 600;
    exp_q.push_back(0);
    exp_q.push_back(0);
    wr(5'h00, 32'h103);
    wait_stat("cont_done1", 32'h100, 32'h100);
    wr(5'h04, 32'h100);
    wait_stat("cont_done2", 32'h100, 32'h100);
    wr(5'h00, 32'h000);
    wait_stat("cont_idle", 32'h1, 32'h0);
    chk("cont_shots_left", exp_q.size(), 0);
    rd(5'h08, r); chk("cont_data0", r, 32'h8000000A);
    rd(5'h04, r); chk("cont_stat", r, 32'h100);

    // START while busy is ignored; interrupt follows the flags
    wait_echo_low();
    wr(5'h04, 32'h000F_0F00);
    exp_q.push_back(0);
    wr(5'h00, 32'h105);
    wr(5'h00, 32'h105);
    rd(5'h00, r);
`ifdef US_IRQ_EN
    chk("irq_ctrl_rd", r, 32'h104);
`else
    chk("irq_ctrl_rd", r, 32'h100);
`endif
    wait_stat("irq_done", 32'h100, 32'h100);
`ifdef US_IRQ_EN
    chk("irq_set", 32'(irq), 1);
`else
    chk("irq_set", 32'(irq), 0);
`endif
    wr(5'h04, 32'h100);
    @(posedge PCLK); #1;
    chk("irq_clr", 32'(irq), 0);
    wait_stat("busy_idle", 32'h1, 32'h0);
    chk("busy_shots_left", exp_q.size(), 0);

    // reset asserted while the echo is high
    wait_echo_low();
    echo_us0 = 1200;
    exp_q.push_back(0);
    wr(5'h00, 32'h101);
    begin
      int n;
      n = 0;
      while (!echo_r0 && n < 2000) begin @(posedge PCLK); n++; end
      if (!echo_r0) timeout("rst_mid_echo");
    end
    repeat (100) @(posedge PCLK);
    rd(5'h04, r);
    chk("mid_busy", r & 32'h1, 32'h1);
    #2 PRESET = 1'b0;
    #1;
    chk("mid_rst_trigger", 32'(trigger), 0);
    chk("mid_rst_pready", 32'(PREADY), 0);
    chk("mid_rst_prdata", PRDATA, 0);
    chk("mid_rst_irq", 32'(irq), 0);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    rd(5'h00, r); chk("mid_ctrl", r, 0);
    rd(5'h04, r); chk("mid_stat", r, 0);
    rd(5'h08, r); chk("mid_data0", r, 0);
    rd(5'h0C, r); chk("mid_data1", r, 0);
    wait_echo_low();
    repeat (50) @(posedge PCLK);

    chk("final_shots_left", exp_q.size(), 0);
    chk("no_overlap", 32'(overlap_seen), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/us_ranger_apb.md
Name: us_ranger_apb

Overview:
- APB-attached multi-channel ultrasonic ranger. It is the parametrised successor to the single-channel ultrasound peripheral.
- Services up to 4 HC-SR04-class sensors. Sensors are fired one at a time in round-robin order with an inter-shot holdoff, so they do not crosstalk.
- Supports single sweep or continuous sweep, per-channel result registers with valid/error flags, and an optional interrupt.
- Sits on the RISC-V APB bus beside the other peripherals.

Parameters:
- NUM_CH, 2, number of sensor channels (1..4)
- CLK_HZ, 100_000_000, PCLK frequency; 1 us tick divisor = CLK_HZ/1_000_000
- TRIG_US, 10, trigger pulse width in us
- WAIT_MAX_US, 5000, max wait from trigger end to echo rise
- ECHO_MAX_US, 25000, max echo-high duration
- GAP_US, 60000, holdoff after each shot before the next trigger
- DIST_W, 9, distance field width in cm

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset; one clock domain; reset is asynchronous and active-low
- PADDR  in  5  byte address, word aligned
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  APB write
- PWDATA  in  32  write data
- PRDATA  out  32  read data
- PREADY  out  1  transfer complete
- trigger  out  NUM_CH  per-channel trigger, one-hot or zero
- echo  in  NUM_CH  per-channel echo, asynchronous
- irq  out  1  level interrupt

Behaviour:
- Reset values: PRDATA=0, PREADY=0, trigger=0, irq=0, all registers 0, FSM IDLE. trigger drops immediately on reset assertion, including mid-shot.
- APB handshake:
  - One wait state. PREADY <= PSEL&PENABLE&!PREADY, so it is high for exactly 1 cycle.
  - PRDATA is registered at the same edge.
  - A write commits at the edge that raises PREADY.
  - Unmapped addresses read 0; writes to them are ignored.
- Register map:
  - 0x00 CTRL: [0] START (write-1 pulse, reads 0); [1] CONT; [2] IRQ_EN; [8+NUM_CH-1:8] CH_EN mask.
  - 0x04 STAT: [0] BUSY (RO); [8+k] DONE_k (W1C); [16+k] ERR_k (W1C).
  - 0x08+4k DATA_k: [DIST_W-1:0] distance; [31] VALID.
- START handling:
  - START with BUSY=0 and CH_EN!=0: BUSY=1, fire the lowest enabled channel.
  - START with BUSY=1 is ignored.
  - START with CH_EN=0 is ignored.
- 1 us tick prescaler: free-running only while the FSM is not in IDLE; cleared in IDLE.
- Echo: 2-FF synchroniser per channel; edge detect on synchronised values.
- FSM:
  - IDLE -> TRIG on accepted START.
  - TRIG: trigger[ch]=1 for TRIG_US ticks, then -> WAIT.
  - WAIT: echo rise -> HIGH; WAIT_MAX_US ticks elapsed -> ERR, set ERR_ch.
  - HIGH: count us ticks. Echo fall -> DONE: DATA_ch = {VALID=1, dist}, set DONE_ch. ECHO_MAX_US reached -> set ERR_ch, DATA_ch = 0.
  - DONE/ERR -> GAP for GAP_US ticks, then either:
    - next enabled channel above ch -> TRIG;
    - sweep complete and CONT=1 -> lowest enabled channel -> TRIG;
    - otherwise IDLE, BUSY=0.
- Distance:
  - dist = (count_us*1130)>>16, which is ~/58.
  - Product is computed at full width, then saturated to 2^DIST_W-1.
  - Count saturates at ECHO_MAX_US.
- Echo already high at WAIT entry: no rise occurs -> wait timeout -> ERR.
- Echo glitch shorter than 2 PCLK cycles is not guaranteed to be seen.
- Status-bit collisions: a hardware set and a W1C on the same cycle resolve to set.
- CH_EN or CONT changed mid-sweep: takes effect at the next channel selection. Clearing CONT ends the sweep at its end.
- A channel disabled while active finishes its current shot.

Optional Feature:
- Macro: US_IRQ_EN.
- Defined: irq = IRQ_EN & |(DONE|ERR), registered, 1-cycle latency after flag set; CTRL[2] is R/W.
- Undefined: irq tied 0; CTRL[2] reads 0 and writes are ignored.

Test Plan:
- Reset, then CTRL=0x103 (CONT=1, CH0 only), then CTRL=0x000 after the first DONE -> trigger[0] high exactly 1000 PCLK cycles; after CTRL=0x000 the sweep stops at its end and BUSY=0.
- NUM_CH=2, CTRL=0x301, echo0 high 580 us, echo1 high 1160 us -> DATA0=0x8000000A, DATA1=0x80000014, STAT=0x00000300, BUSY=0 after second GAP, trigger[1] never overlaps trigger[0].
- CTRL=0x101, echo0 held low -> ERR_0 set 5000 us after trigger fall, DATA0=0; W1C 0x10000 -> STAT=0.
- echo0 high for 30000 us -> ERR_0 at 25000 us count, DATA0 VALID=0, next shot waits full GAP.
- US_IRQ_EN defined, CTRL=0x105, 580 us echo -> irq=1 one cycle after DONE_0; write STAT=0x100 -> irq=0; START during BUSY -> no extra trigger.
- PRESET asserted mid-HIGH -> trigger=0, PREADY=0, all registers 0 immediately; unmapped read at 0x1C -> PRDATA=0 with single-cycle PREADY.
